// File: rtl/keypad_time_entry.sv
// Keypad time entry: debounces encoder presses and shifts accepted digits into a 4-digit BCD MM:SS register.
// Optional macro ENTRY_LIMIT_EN: once four digits are entered, further presses are ignored until clear/reset.
module keypad_time_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] digit,
  input  logic       validn,
  input  logic       clearn,
  input  logic       lock,
  output logic [3:0] sec_units,
  output logic [3:0] sec_tens,
  output logic [3:0] min_units,
  output logic [3:0] min_tens,
  output logic [2:0] digit_count,
  output logic       key_strobe
);
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             validn_s;
  logic [3:0]       digit_s;
  logic [3:0]       cap_digit;
  logic             room;
  logic             accept;
  logic             shift_en;

`ifdef ENTRY_LIMIT_EN
  assign room = (digit_count != 3'd4);
`else
  assign room = 1'b1;
`endif

  // A press is accepted once, at the edge its stable run reaches the full window.
  assign accept   = (state == PRESS_DB) && !validn_s && (digit_s == cap_digit) && (cnt == CNT_MAX);
  assign shift_en = accept && (cap_digit <= 4'd9) && !lock && clearn && room;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      validn_s    <= 1'b1;
      digit_s     <= 4'd0;
      cap_digit   <= 4'd0;
      sec_units   <= 4'd0;
      sec_tens    <= 4'd0;
      min_units   <= 4'd0;
      min_tens    <= 4'd0;
      digit_count <= 3'd0;
      key_strobe  <= 1'b0;
    end else begin
      validn_s   <= validn;
      digit_s    <= digit;
      key_strobe <= 1'b0;

      case (state)
        IDLE: begin
          if (!validn_s) begin
            state     <= PRESS_DB;
            cnt       <= CNT_ONE;
            cap_digit <= digit_s;
          end
        end
        PRESS_DB: begin
          if (validn_s || (digit_s != cap_digit)) state <= IDLE;
          else if (cnt == CNT_MAX)                state <= HELD;
          else                                    cnt   <= cnt + CNT_ONE;
        end
        HELD: begin
          if (validn_s) begin
            state <= RELEASE_DB;
            cnt   <= CNT_ONE;
          end
        end
        RELEASE_DB: begin
          if (!validn_s)           state <= HELD;
          else if (cnt == CNT_MAX) state <= IDLE;
          else                     cnt   <= cnt + CNT_ONE;
        end
        default: state <= IDLE;
      endcase

      // Clear wins over a coincident accept.
      if (!clearn) begin
        sec_units   <= 4'd0;
        sec_tens    <= 4'd0;
        min_units   <= 4'd0;
        min_tens    <= 4'd0;
        digit_count <= 3'd0;
      end else if (shift_en) begin
        min_tens    <= min_units;
        min_units   <= sec_tens;
        sec_tens    <= sec_units;
        sec_units   <= cap_digit;
        digit_count <= (digit_count == 3'd4) ? 3'd4 : digit_count + 3'd1;
        key_strobe  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_keypad_time_entry.sv
// Scoreboard bench for keypad_time_entry: stimulus pushes expected strobe results, a monitor pops them.
module tb_keypad_time_entry;
  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       resetn, validn, clearn, lock;
  logic [3:0] digit;
  logic [3:0] sec_units, sec_tens, min_units, min_tens;
  logic [2:0] digit_count;
  logic       key_strobe;

  typedef struct {
    logic [15:0] digits;
    logic [2:0]  count;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  keypad_time_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .resetn(resetn), .digit(digit), .validn(validn),
    .clearn(clearn), .lock(lock),
    .sec_units(sec_units), .sec_tens(sec_tens), .min_units(min_units),
    .min_tens(min_tens), .digit_count(digit_count), .key_strobe(key_strobe)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [15:0] entry();
    return {min_tens, min_units, sec_tens, sec_units};
  endfunction

  // Monitor: every strobe must match the oldest expected accept.
  always @(negedge clock) begin
    if (key_strobe) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_strobe at cycle %0d entry=%h count=%0d", cyc, entry(), digit_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        vectors += 3;
        if (entry() !== e.digits) begin
          miscompares++;
          $display("FAIL strobe_digits got %h want %h", entry(), e.digits);
        end
        if (digit_count !== e.count) begin
          miscompares++;
          $display("FAIL strobe_count got %0d want %0d", digit_count, e.count);
        end
        if (cyc != e.cyc) begin
          miscompares++;
          $display("FAIL strobe_latency got cycle %0d want %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic check_state(input string name, input logic [15:0] ed, input logic [2:0] ec);
    vectors++;
    if (entry() !== ed || digit_count !== ec) begin
      miscompares++;
      $display("FAIL %s got %h/%0d want %h/%0d", name, entry(), digit_count, ed, ec);
    end
  endtask

  // Clean press of d held for `hold` cycles, then full release.
  task automatic press(input logic [3:0] d, input int hold, input bit exp_st,
                       input logic [15:0] ed, input logic [2:0] ec);
    @(posedge clock); #1;
    digit = d; validn = 1'b0;
    if (exp_st) sb.push_back('{ed, ec, cyc + DB + 2});
    repeat (hold) @(posedge clock);
    #1 validn = 1'b1;
    repeat (DB + 4) @(posedge clock);
    #1;
  endtask

  task automatic clear_pulse();
    @(posedge clock); #1 clearn = 1'b0;
    @(posedge clock); #1 clearn = 1'b1;
    check_state("clear", 16'h0000, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; validn = 1'b1; clearn = 1'b1; lock = 1'b0; digit = 4'd0;
    repeat (3) @(posedge clock);
    #1;
    check_state("reset", 16'h0000, 3'd0);
    vectors++;
    if (key_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobe got %b want 0", key_strobe);
    end
    resetn = 1'b1;

    press(4'd5, 10, 1, 16'h0005, 3'd1);
    check_state("first_digit", 16'h0005, 3'd1);

    clear_pulse();
    press(4'd1, 10, 1, 16'h0001, 3'd1);
    press(4'd2, 10, 1, 16'h0012, 3'd2);
    press(4'd3, 10, 1, 16'h0123, 3'd3);
    press(4'd0, 10, 1, 16'h1230, 3'd4);
`ifdef ENTRY_LIMIT_EN
    press(4'd7, 10, 0, 16'h0000, 3'd0);
    check_state("limit_fifth", 16'h1230, 3'd4);
`else
    press(4'd7, 10, 1, 16'h2307, 3'd4);
    check_state("shift_fifth", 16'h2307, 3'd4);
`endif

    // Non-decimal code: held and released, but never entered.
    clear_pulse();
    press(4'hA, 10, 0, 16'h0000, 3'd0);
    check_state("non_bcd", 16'h0000, 3'd0);

    // Bounce: two short low runs never reach the window.
    @(posedge clock); #1 digit = 4'd6; validn = 1'b0;
    repeat (2) @(posedge clock); #1 validn = 1'b1;
    @(posedge clock); #1 validn = 1'b0;
    repeat (2) @(posedge clock); #1 validn = 1'b1;
    repeat (DB + 4) @(posedge clock); #1;
    check_state("bounce", 16'h0000, 3'd0);
    press(4'd6, 20, 1, 16'h0006, 3'd1);

    // Digit change while held must not produce a second accept.
    @(posedge clock); #1 digit = 4'd3; validn = 1'b0;
    sb.push_back('{16'h0063, 3'd2, cyc + DB + 2});
    repeat (10) @(posedge clock); #1 digit = 4'd4;
    repeat (10) @(posedge clock); #1 validn = 1'b1;
    repeat (DB + 4) @(posedge clock); #1;
    check_state("held_change", 16'h0063, 3'd2);

    // Lock during press of 8, unlocked while still held: needs release and re-press.
    lock = 1'b1;
    @(posedge clock); #1 digit = 4'd8; validn = 1'b0;
    repeat (10) @(posedge clock); #1 lock = 1'b0;
    repeat (10) @(posedge clock); #1 validn = 1'b1;
    repeat (DB + 4) @(posedge clock); #1;
    check_state("lock", 16'h0063, 3'd2);
    press(4'd8, 10, 1, 16'h0638, 3'd3);

    // Clear coincident with the accept edge of 9.
    clear_pulse();
    press(4'd4, 10, 1, 16'h0004, 3'd1);
    press(4'd2, 10, 1, 16'h0042, 3'd2);
    @(posedge clock); #1 digit = 4'd9; validn = 1'b0;
    repeat (DB + 1) @(posedge clock); #1 clearn = 1'b0;
    @(posedge clock); #1 clearn = 1'b1;
    check_state("clear_on_accept", 16'h0000, 3'd0);
    repeat (5) @(posedge clock); #1 validn = 1'b1;
    repeat (DB + 4) @(posedge clock); #1;
    check_state("clear_after_release", 16'h0000, 3'd0);

    // Reset in the middle of PRESS_DB with the key still held.
    press(4'd1, 10, 1, 16'h0001, 3'd1);
    @(posedge clock); #1 digit = 4'd7; validn = 1'b0;
    repeat (2) @(posedge clock); #1 resetn = 1'b0;
    @(posedge clock); #1;
    check_state("mid_press_reset", 16'h0000, 3'd0);
    resetn = 1'b1;
    sb.push_back('{16'h0007, 3'd1, cyc + DB + 2});
    repeat (12) @(posedge clock); #1 validn = 1'b1;
    repeat (DB + 4) @(posedge clock); #1;
    check_state("after_reset_press", 16'h0007, 3'd1);

    repeat (4) @(posedge clock); #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_strobes got %0d pending want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
